// File: rtl/scr1_accel_dense.sv
// scr1_accel_dense: memory-mapped dense-layer engine on the SCR1 data-memory
// port. Software loads biases, weights and one input vector and writes GO.
// The sequencer then computes bias + sum(w*x) per neuron with one MAC per
// cycle, requantises with an arithmetic right shift and optional ReLU, and
// tracks the argmax. Bus encodings follow the SCR1 memory interface:
// cmd RD=0/WR=1, width BYTE=0/HWORD=1/WORD=2, resp NOTRDY=0/RDY_OK=1.
module scr1_accel_dense #(
  parameter int N_NEURONS = 10,
  parameter int N_INPUTS  = 49,
  parameter int W_DATA    = 16,
  parameter int W_ACC     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        dmem_req_ack,
  input  logic        dmem_req,
  input  logic        dmem_cmd,
  input  logic [1:0]  dmem_width,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic [1:0]  dmem_resp,
  output logic        irq
);

  localparam int N_W = N_NEURONS * N_INPUTS;
  localparam int NB  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int IB  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int WB  = (N_W > 1) ? $clog2(N_W) : 1;

  localparam logic       CMD_WR      = 1'b1;
  localparam logic [1:0] WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] WIDTH_HWORD = 2'b01;
  localparam logic [1:0] RESP_NOTRDY = 2'b00;
  localparam logic [1:0] RESP_OK     = 2'b01;

  localparam logic [31:0] IDX_CTRL   = 32'd0;
  localparam logic [31:0] IDX_STATUS = 32'd1;
  localparam logic [31:0] IDX_ARGMAX = 32'd2;
  localparam logic [31:0] BIAS_BASE  = 32'd16;
  localparam logic [31:0] X_BASE     = 32'd64;
  localparam logic [31:0] RES_BASE   = 32'd128;
  localparam logic [31:0] W_BASE     = 32'd256;
  localparam logic [31:0] BIAS_END   = 32'(16 + N_NEURONS);
  localparam logic [31:0] X_END      = 32'(64 + N_INPUTS);
  localparam logic [31:0] RES_END    = 32'(128 + N_NEURONS);
  localparam logic [31:0] W_END      = 32'(256 + N_W);

  localparam logic [NB-1:0] N_LAST = NB'(N_NEURONS - 1);
  localparam logic [IB-1:0] I_LAST = IB'(N_INPUTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_STORE} state_t;

  // Storage
  logic signed [W_ACC-1:0]  r_bias [N_NEURONS];
  logic signed [W_DATA-1:0] r_x    [N_INPUTS];
  logic signed [W_DATA-1:0] r_w    [N_W];
  logic signed [W_ACC-1:0]  r_res  [N_NEURONS];

  // Control / status
  state_t                  r_state, w_state_nxt;
  logic                    r_relu, r_irq_en, r_done;
  logic [4:0]              r_shift;
  logic [15:0]             r_cycles;
  logic [NB-1:0]           r_n, r_argmax;
  logic [IB-1:0]           r_i;
  logic [WB-1:0]           r_wptr;
  logic signed [W_ACC-1:0] r_acc, r_max;
  logic [31:0]             r_rdata;
  logic [1:0]              r_resp;

  logic [31:0]               w_widx, w_wdata, w_rd_word;
  logic [31:0]               w_off_b, w_off_x, w_off_r, w_off_w;
  logic                      w_hit_b, w_hit_x, w_hit_r, w_hit_w;
  logic                      w_wr, w_rd, w_ctrl_wr, w_start, w_abort, w_w1c;
  logic                      w_busy, w_load_en, w_mac_en, w_store_en, w_last;
  logic signed [2*W_DATA-1:0] w_prod;
  logic signed [W_ACC-1:0]   w_prod_ext, w_res;
  logic                      w_unused_bits;

  // Arithmetic right shift by SHIFT, then clamp negatives when ReLU is on.
  function automatic logic signed [W_ACC-1:0] requant(
    input logic signed [W_ACC-1:0] acc,
    input logic [4:0]              sh,
    input logic                    relu
  );
    logic signed [W_ACC-1:0] r;
    r = acc >>> sh;
    if (relu && r[W_ACC-1]) r = '0;
    return r;
  endfunction

  // Busy-cycle counter that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic [31:0] sext_acc(input logic signed [W_ACC-1:0] v);
    return 32'(v);
  endfunction

  function automatic logic [31:0] sext_data(input logic signed [W_DATA-1:0] v);
    return 32'(v);
  endfunction

  assign dmem_req_ack = 1'b1;
  assign dmem_rdata   = r_rdata;
  assign dmem_resp    = r_resp;
  assign irq          = r_done & r_irq_en;

  assign w_widx  = {22'd0, dmem_addr[11:2]};
  assign w_off_b = w_widx - BIAS_BASE;
  assign w_off_x = w_widx - X_BASE;
  assign w_off_r = w_widx - RES_BASE;
  assign w_off_w = w_widx - W_BASE;
  assign w_hit_b = (w_widx >= BIAS_BASE) && (w_widx < BIAS_END);
  assign w_hit_x = (w_widx >= X_BASE) && (w_widx < X_END);
  assign w_hit_r = (w_widx >= RES_BASE) && (w_widx < RES_END);
  assign w_hit_w = (w_widx >= W_BASE) && (w_widx < W_END);
  assign w_unused_bits = ^{dmem_addr[31:12], w_off_b, w_off_x, w_off_r, w_off_w};

  assign w_wr      = dmem_req && (dmem_cmd == CMD_WR);
  assign w_rd      = dmem_req && (dmem_cmd != CMD_WR);
  assign w_ctrl_wr = w_wr && (w_widx == IDX_CTRL);
  // ABORT in the same word as GO suppresses the start.
  assign w_start   = w_ctrl_wr && w_wdata[0] && !w_wdata[3] && (r_state == S_IDLE);
  assign w_abort   = w_ctrl_wr && w_wdata[3] && (r_state != S_IDLE);
  assign w_w1c     = w_wr && (w_widx == IDX_STATUS) && w_wdata[0];

  assign w_prod     = r_w[r_wptr] * r_x[r_i];
  assign w_prod_ext = W_ACC'(w_prod);
  assign w_res      = requant(r_acc, r_shift, r_relu);

  // Sub-word writes replicate the lane across the whole word.
  always_comb begin
    case (dmem_width)
      WIDTH_BYTE:  w_wdata = {4{dmem_wdata[7:0]}};
      WIDTH_HWORD: w_wdata = {2{dmem_wdata[15:0]}};
      default:     w_wdata = dmem_wdata;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Sequencer next state; ABORT overrides every busy transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_MAC;
      S_MAC:   if (r_i == I_LAST) w_state_nxt = S_STORE;
      S_STORE: w_state_nxt = (r_n == N_LAST) ? S_IDLE : S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  // Sequencer outputs: per-state datapath enables, squashed by ABORT.
  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_load_en  = (r_state == S_LOAD) && !w_abort;
    w_mac_en   = (r_state == S_MAC) && !w_abort;
    w_store_en = (r_state == S_STORE) && !w_abort;
    w_last     = (r_state == S_STORE) && !w_abort && (r_n == N_LAST);
  end

  // Software-loaded operands (frozen while busy) and computed results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) r_bias[k] <= '0;
      for (int k = 0; k < N_INPUTS; k++)  r_x[k]    <= '0;
      for (int k = 0; k < N_W; k++)       r_w[k]    <= '0;
      for (int k = 0; k < N_NEURONS; k++) r_res[k]  <= '0;
    end else begin
      if (w_wr && !w_busy) begin
        if (w_hit_b) r_bias[w_off_b[NB-1:0]] <= w_wdata[W_ACC-1:0];
        if (w_hit_x) r_x[w_off_x[IB-1:0]]    <= w_wdata[W_DATA-1:0];
        if (w_hit_w) r_w[w_off_w[WB-1:0]]    <= w_wdata[W_DATA-1:0];
      end
      if (w_store_en) r_res[r_n] <= w_res;
    end
  end

  // CTRL fields, DONE flag (set beats W1C) and saturating busy-cycle count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_relu   <= 1'b0;
      r_irq_en <= 1'b0;
      r_shift  <= '0;
      r_done   <= 1'b0;
      r_cycles <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_relu   <= w_wdata[1];
        r_irq_en <= w_wdata[2];
        r_shift  <= w_wdata[12:8];
      end
      if (w_last)                 r_done <= 1'b1;
      else if (w_start || w_w1c)  r_done <= 1'b0;
      if (w_start)     r_cycles <= '0;
      else if (w_busy) r_cycles <= sat_inc16(r_cycles);
    end
  end

  // MAC datapath: neuron/input indices, weight pointer, accumulator, argmax.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n      <= '0;
      r_i      <= '0;
      r_wptr   <= '0;
      r_acc    <= '0;
      r_argmax <= '0;
      r_max    <= '0;
    end else begin
      if (w_start) begin
        r_n      <= '0;
        r_wptr   <= '0;
        r_argmax <= '0;
        r_max    <= '0;
      end
      if (w_load_en) begin
        r_acc <= r_bias[r_n];
        r_i   <= '0;
      end
      if (w_mac_en) begin
        r_acc  <= r_acc + w_prod_ext;
        r_i    <= r_i + IB'(1);
        r_wptr <= r_wptr + WB'(1);
      end
      if (w_store_en) begin
        if ((r_n == '0) || (w_res > r_max)) begin
          r_max    <= w_res;
          r_argmax <= r_n;
        end
        if (r_n != N_LAST) r_n <= r_n + NB'(1);
      end
    end
  end

  // Read decode of the current register image.
  always_comb begin
    w_rd_word = '0;
    if (w_widx == IDX_CTRL)        w_rd_word = {w_busy, 18'd0, r_shift, 5'd0, r_irq_en, r_relu, 1'b0};
    else if (w_widx == IDX_STATUS) w_rd_word = {r_cycles, 14'd0, w_busy, r_done};
    else if (w_widx == IDX_ARGMAX) w_rd_word = 32'(r_argmax);
    else if (w_hit_b)              w_rd_word = sext_acc(r_bias[w_off_b[NB-1:0]]);
    else if (w_hit_x)              w_rd_word = sext_data(r_x[w_off_x[IB-1:0]]);
    else if (w_hit_r)              w_rd_word = sext_acc(r_res[w_off_r[NB-1:0]]);
    else if (w_hit_w)              w_rd_word = sext_data(r_w[w_off_w[WB-1:0]]);
  end

  // Bus response: RDY_OK one cycle after every request, read data lane-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp  <= RESP_NOTRDY;
      r_rdata <= '0;
    end else begin
      r_resp <= dmem_req ? RESP_OK : RESP_NOTRDY;
      if (w_rd) r_rdata <= w_rd_word >> {dmem_addr[1:0], 3'b000};
    end
  end

endmodule

// File: doc/scr1_accel_dense.md
Name: scr1_accel_dense

Overview:
Memory-mapped dense-layer engine on the SCR1 data-memory interface. Software loads biases, weights and one input vector, then writes GO. An internal FSM computes every neuron as bias + Σ w·x with one MAC per cycle, then applies a requantising shift and optional ReLU. It also tracks the argmax and raises a done flag and an optional interrupt. Successor to the passive layer register bank: the MAC, sequencing, status and abort now live in the block.

Parameters:
N_NEURONS, 10, neurons per layer (1..48)
N_INPUTS, 49, inputs per neuron (1..64); 256+N_NEURONS*N_INPUTS must be ≤1024
W_DATA, 16, signed width of weights and inputs
W_ACC, 32, signed accumulator/bias/result width (≥2*W_DATA, ≤32)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
dmem_req_ack  out  1  request accept, tied 1
dmem_req  in  1  request valid
dmem_cmd  in  type_scr1_mem_cmd_e  RD/WR
dmem_width  in  type_scr1_mem_width_e  byte/hword/word
dmem_addr  in  `SCR1_DMEM_AWIDTH  byte address; word index = addr[11:2]
dmem_wdata  in  `SCR1_DMEM_DWIDTH  write data
dmem_rdata  out  `SCR1_DMEM_DWIDTH  read data, valid with RDY_OK
dmem_resp  out  type_scr1_mem_resp_e  response
irq  out  1  level interrupt = DONE & IRQ_EN

Behaviour:
- Reset: all storage, results, CTRL, DONE, counters, argmax = 0; state IDLE; dmem_resp = NOTRDY; dmem_rdata = 0; irq = 0.
- Bus: each accepted req gives dmem_resp = RDY_OK on the next cycle, otherwise NOTRDY. Read data is registered from the request-cycle address and shifted right by 8*addr[1:0].
- Sub-word writes replicate the byte/hword across the 32-bit word, and the whole word is written.
- Register map (word index):
  - 0 CTRL: b0 GO (write-1 pulse, reads 0); b1 RELU_EN; b2 IRQ_EN; b3 ABORT (write-1 pulse); b12:8 SHIFT. Read also returns b31 = BUSY.
  - 1 STATUS: b0 DONE (write-1-to-clear); b1 BUSY; b31:16 cycle count.
  - 2 ARGMAX: index of the max result, zero-extended.
  - 16+n: bias[n]. 64+i: input[i]. 128+n: result[n] (read-only). 256+n*N_INPUTS+i: weight[n][i].
  - Unmapped indices read 0; writes to them are ignored.
- Storage: keeps the low W_DATA (weights/inputs) or W_ACC (bias) bits; reads sign-extend to 32 bits.
- FSM states and transitions:
  - IDLE: on GO write → LOAD. Same edge sets BUSY, clears DONE, cycle count, n and argmax.
  - LOAD: acc ← sign-extended bias[n]; i ← 0 → MAC.
  - MAC: acc ← acc + w[n][i]*x[i] (signed, wraps mod 2^W_ACC); i++. At i = N_INPUTS-1 → STORE.
  - STORE: r = acc >>> SHIFT (arithmetic); if RELU_EN and r<0 then r = 0. result[n] ← r.
    - Argmax: updates if n==0 or r > current max (signed, strict, so ties keep the lowest index).
    - If n = N_NEURONS-1: DONE←1, BUSY←0 → IDLE. Else n++ → LOAD.
- Latency: DONE is set exactly N_NEURONS*(N_INPUTS+2) edges after the edge that samples GO (defaults: 510).
- Cycle count increments every busy cycle and saturates at 0xFFFF.
- While BUSY:
  - Writes to bias, input or weight and GO writes are dropped, but still return RDY_OK.
  - Reads are allowed; partially written results are visible.
- ABORT while BUSY: next edge → IDLE, BUSY=0, DONE unchanged; completed results are kept. ABORT in IDLE has no effect.
- GO and ABORT in the same write: ABORT wins.
- DONE set and W1C on the same edge: set wins.
- Reset mid-run: returns immediately to the reset state.

Test Plan:
- Reset, then read words 0, 1, 2 and 128 → all 0; irq 0; each read gets RDY_OK one cycle after req.
- Defaults; bias[n]=n; all x=1; weight[n][i]=1; GO; poll STATUS → DONE at edge 510; result[n] = 49+n; ARGMAX = 9; cycle count = 510.
- RELU_EN=1, SHIFT=2, bias[3] = -100, other settings as the previous test → result[3] = 0. Same with RELU_EN=0 → result[3] = -13 (0xFFFFFFF3).
- Two neurons tie at value 50 (indices 4 and 7), all others lower → ARGMAX = 4.
- IRQ_EN=1; run to completion → irq=1. W1C STATUS b0 → irq=0 the next cycle. Byte write 0x01 to STATUS → also clears DONE.
- Mid-run: write weight[0][0] and GO (both ignored), then ABORT at cycle 100 → BUSY=0, DONE=0, result[0] matches the first test. Assert rst_n mid-run → all registers read 0.
